// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan controller.
// HEX_SEG holds the active-high gfedcba pattern for each hex nibble.
package seg_pkg;

  localparam int unsigned DIGITS_DEF = 8;
  localparam int unsigned DIV_DEF    = 100000;
  localparam int unsigned GUARD_DEF  = 2;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-high gfedcba segment decoder.
module seg7_decode
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg_c
);

  assign seg_c = HEX_SEG[nib];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scanner: per-frame input snapshot, leading-zero
// blanking, per-digit masking, anode guard time and registered SEG/AN.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned DIGITS     = DIGITS_DEF,
  parameter int unsigned DIV        = DIV_DEF,
  parameter int unsigned GUARD      = GUARD_DEF,
  parameter int unsigned ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     en_mask,
  input  logic                  blank_lz,
  input  logic                  freeze,
  output logic [7:0]            SEG,
  output logic [DIGITS-1:0]     AN,
  output logic                  frame
);

  localparam int unsigned CW = $clog2(DIV);
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic        POL = (ACTIVE_LOW != 0);
  localparam logic [7:0]        SEG_OFF = {8{POL}};
  localparam logic [DIGITS-1:0] AN_OFF  = {DIGITS{POL}};

  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic                load_pending;
  logic [4*DIGITS-1:0] snap_data;
  logic [DIGITS-1:0]   snap_dp;
  logic [DIGITS-1:0]   snap_en;
  logic                snap_blz;

  logic                tick_c;
  logic                wrap_c;
  logic                in_guard_c;
  logic                blank_c;
  logic                lit_c;
  logic [3:0]          nib_c;
  logic [6:0]          hex_c;
  logic [7:0]          seg_nxt_c;
  logic [DIGITS-1:0]   an_nxt_c;

  assign tick_c = (cnt == CW'(DIV - 1));
  assign wrap_c = tick_c && (idx == IW'(DIGITS - 1));

  // Prescaler and digit index; a reset abandons the scan and restarts at slot 0.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= tick_c ? '0 : cnt + CW'(1);
      if (tick_c) begin
        idx <= wrap_c ? '0 : idx + IW'(1);
      end
    end
  end

  // Snapshot reloads on each frame unless frozen; the first edge after reset always loads.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      load_pending <= 1'b1;
      snap_data    <= '0;
      snap_dp      <= '0;
      snap_en      <= '0;
      snap_blz     <= 1'b0;
    end else begin
      load_pending <= 1'b0;
      if (load_pending || (wrap_c && !freeze)) begin
        snap_data <= data;
        snap_dp   <= dp;
        snap_en   <= en_mask;
        snap_blz  <= blank_lz;
      end
    end
  end

  if (GUARD == 0) begin : g_no_guard
    assign in_guard_c = 1'b0;
  end else begin : g_guard
    assign in_guard_c = (cnt < CW'(GUARD));
  end

  // Digit idx is a leading zero when it and every more significant nibble are zero.
  assign blank_c = snap_blz && (idx != '0) && ((snap_data >> {idx, 2'b00}) == '0);
  assign nib_c   = 4'(snap_data >> {idx, 2'b00});
  assign lit_c   = snap_en[idx] && !blank_c && !in_guard_c;

  seg7_decode u_decode (
    .nib   (nib_c),
    .seg_c (hex_c)
  );

  assign seg_nxt_c = lit_c ? {snap_dp[idx], hex_c} : 8'h00;
  assign an_nxt_c  = lit_c ? (DIGITS'(1) << idx) : '0;

  // XOR with the off pattern applies output polarity.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      SEG   <= SEG_OFF;
      AN    <= AN_OFF;
      frame <= 1'b0;
    end else begin
      SEG   <= seg_nxt_c ^ SEG_OFF;
      AN    <= an_nxt_c ^ AN_OFF;
      frame <= wrap_c;
    end
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter DIGITS, default 8: number of multiplexed digits, range 1..16.
REQ-002 SHALL have parameter DIV, default 100000: clk cycles per digit slot, minimum 2.
REQ-003 SHALL have parameter GUARD, default 2: anode-off cycles at the start of each slot, range 0..DIV-1.
REQ-004 SHALL have parameter ACTIVE_LOW, default 1: when 1, SEG and AN drive 0 for lit/selected.
REQ-005 SHALL have port clk, input, 1: the single clock.
REQ-006 SHALL have port clr, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port data, input, 4*DIGITS: hex nibbles; nibble i drives digit i, digit 0 rightmost.
REQ-008 SHALL have port dp, input, DIGITS: decimal point per digit.
REQ-009 SHALL have port en_mask, input, DIGITS: 0 forces that digit dark.
REQ-010 SHALL have port blank_lz, input, 1: leading-zero blanking enable.
REQ-011 SHALL have port freeze, input, 1: inhibits snapshot reload.
REQ-012 SHALL have port SEG, output, 8: bit 7 = DP, bits 6..0 = gfedcba.
REQ-013 SHALL have port AN, output, DIGITS: one-hot digit select.
REQ-014 SHALL have port frame, output, 1: one-cycle pulse at each completed scan.

Function
REQ-015 SHALL run a prescaler cnt that counts 0..DIV-1 and wraps; tick SHALL be asserted when cnt==DIV-1.
REQ-016 SHALL advance digit index idx on tick, wrapping from DIGITS-1 to 0.
REQ-017 SHALL assert frame for exactly the tick cycle on which idx wraps from DIGITS-1 to 0.
REQ-018 SHALL copy data, dp and en_mask into snapshot registers on the frame cycle when freeze==0; when freeze==1, the snapshot SHALL hold.
REQ-019 SHALL perform one snapshot load on the first clk edge after reset release, regardless of freeze, via an internal load_pending flag.
REQ-020 SHALL compute digit i as blanked when blank_lz==1, i>0, and snapshot nibbles i..DIGITS-1 are all zero; digit 0 SHALL never be blanked by this rule.
REQ-021 SHALL drive no anode during a slot whose digit is blanked or masked; the slot SHALL still consume DIV cycles.
REQ-022 SHALL drive no anode for the first GUARD cycles of every slot (cnt<GUARD); with GUARD==0, the anode SHALL be driven for the whole slot.
REQ-023 SHALL register SEG and AN, so outputs reflect the cnt/idx of the previous cycle (1-cycle latency).
REQ-024 SHALL drive SEG to the decode of snapshot nibble idx, plus snapshot dp[idx], while the anode is driven; otherwise SEG SHALL be all-off.
REQ-025 SHALL invert SEG and AN at the output register when ACTIVE_LOW==1; in that case "off" SHALL mean all ones.
REQ-026 SHALL ignore changes to data, dp, en_mask and blank_lz mid-frame until the next snapshot load; blank_lz SHALL be applied combinationally from the snapshot.
REQ-027 SHALL honour freeze on the frame cycle itself, with no additional latency.

Reset
REQ-028 SHALL, while clr==0, clear cnt, idx and snapshots to 0, set load_pending to 1, set frame to 0, and drive SEG and AN all-off (per ACTIVE_LOW).
REQ-029 SHALL abandon a scan interrupted by clr; after release, scanning SHALL restart at idx 0 with cnt 0, and the first tick SHALL occur DIV cycles after release.

Structure
REQ-030 SHALL place the hex-to-segment table (16 x 7-bit constants, active-high gfedcba) and default DIGITS/DIV/GUARD values in shared package seg_pkg.
REQ-031 SHALL instantiate sub-module seg7_decode (4-bit in, 7-bit active-high out, purely combinational, using the seg_pkg table) once on the selected nibble.
REQ-032 SHALL contain no other sub-modules; the design SHALL be 120-400 RTL lines.

Verification (DIGITS=4, DIV=4, GUARD=1, ACTIVE_LOW=1)
REQ-033 SHALL test: release clr with data=16'h12AF, dp=0, en_mask=4'hF -> frame every 16 cycles; AN sequence 1110,1101,1011,0111; SEG digit0=8'b10001110 ('F'); AN=1111 on the first registered cycle of each slot.
REQ-034 SHALL test: data=16'h0050, blank_lz=1 -> digits 3 and 2 dark, digits 1 and 0 show '5' and '0'; with data=16'h0000, only digit 0 is lit, showing '0'.
REQ-035 SHALL test: freeze=1, then change data to 16'hBEEF mid-frame -> display stays 16'h12AF across 3 frames; drop freeze -> 16'hBEEF appears starting with the slot after the next frame pulse.
REQ-036 SHALL test: en_mask=4'b1010, dp=4'b0001 -> AN never selects digits 0 or 2; DP never lit, because digit 0 is masked.
REQ-037 SHALL test: assert clr in mid-slot of idx=2 -> SEG=8'hFF and AN=4'hF within the same cycle; after release, the first tick occurs at cycle 4 and the first lit digit is digit 0.
REQ-038 SHALL test: GUARD=0 build -> an anode is driven every cycle of each lit slot; frame timing is unchanged.
